// File: rtl/obc_monitor_pkg.sv
// obc_monitor_pkg: state encoding, LFSR polynomial and reference-answer helpers
// shared by the OBC challenge monitor and its LFSR.
package obc_monitor_pkg;
    typedef enum logic [2:0] {IDLE, ASK, GAP, EVAL, SHUTDOWN} state_t;
    // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? (s >> 1) ^ LFSR_POLY : s >> 1;
    endfunction
    function automatic logic [15:0] ref_answer(input logic [15:0] q, input int width);
        logic [15:0] r;
        r = '0;
        r[0] = ~q[0];
        for (int i = 1; i < 16; i++) r[i] = (i < width) ? q[i-1] ^ q[i] : 1'b0;
        return r;
    endfunction
endpackage

// File: rtl/obc_lfsr16.sv
// obc_lfsr16: 16-bit Galois LFSR that reloads its seed on reset and advances
// one step whenever step is high.
module obc_lfsr16
    import obc_monitor_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] state
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= SEED;
        else if (step) state <= lfsr_step(state);
endmodule

// File: rtl/obc_challenge_monitor.sv
// obc_challenge_monitor: periodic challenge-response watchdog for OBC1 with a
// strike budget, sticky failover override and a timed reset pulse.
module obc_challenge_monitor
    import obc_monitor_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          ROUNDS      = 10,
    parameter int          PASS_MIN    = 7,
    parameter int          MAX_STRIKES = 3,
    parameter int          TIMEOUT     = 16,
    parameter int          INTERVAL    = 64,
    parameter int          RST_PULSE   = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic [WIDTH-1:0] question,
    output logic             q_valid,
    input  logic [WIDTH-1:0] answer_obc,
    input  logic             ans_valid,
    output logic             check_pass,
    output logic             check_fail,
    output logic [3:0]       strikes,
    output logic             override,
    output logic             obc_reset
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int CW = $clog2(INTERVAL) + 1;
    localparam int PW = $clog2(RST_PULSE) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] I_LAST = CW'(INTERVAL - 1);
    localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE - 1);
    localparam logic [7:0]    R_N    = 8'(ROUNDS);
    localparam logic [7:0]    P_MIN  = 8'(PASS_MIN);
    localparam logic [3:0]    S_MAX  = 4'(MAX_STRIKES);

    state_t          st;
    logic [CW-1:0]   idle_cnt;
    logic [TW-1:0]   timer;
    logic [7:0]      round, correct;
    logic [PW-1:0]   pulse_cnt;
    logic [15:0]     lfsr;
    logic [WIDTH-1:0] ref_ans;
    logic [3:0]      strikes_inc;
    logic            step, imperfect, to_shut;

    assign ref_ans     = WIDTH'(ref_answer(16'(question), WIDTH));
    assign strikes_inc = (strikes == 4'hF) ? strikes : strikes + 4'd1;
    assign imperfect   = correct != R_N;
    // clear in the EVAL cycle vetoes the shutdown
    assign to_shut     = imperfect && !clear && (correct < P_MIN || strikes_inc == S_MAX);
    assign step        = (st == IDLE && idle_cnt == I_LAST) || (st == GAP && round < R_N);

    obc_lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .reset(reset), .step(step), .state(lfsr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            idle_cnt   <= '0;
            timer      <= '0;
            round      <= '0;
            correct    <= '0;
            pulse_cnt  <= '0;
            question   <= '0;
            q_valid    <= 1'b0;
            check_pass <= 1'b0;
            check_fail <= 1'b0;
            strikes    <= '0;
            override   <= 1'b0;
            obc_reset  <= 1'b0;
        end else begin
            check_pass <= 1'b0;
            check_fail <= 1'b0;
            case (st)
                IDLE: begin
                    if (idle_cnt == I_LAST) begin
                        idle_cnt <= '0;
                        st       <= ASK;
                        q_valid  <= 1'b1;
                        question <= WIDTH'(lfsr_step(lfsr));
                        timer    <= '0;
                        round    <= '0;
                        correct  <= '0;
                    end else idle_cnt <= idle_cnt + 1'b1;
                end
                ASK: begin
                    if (ans_valid || timer == T_LAST) begin
                        st      <= GAP;
                        q_valid <= 1'b0;
                        round   <= round + 8'd1;
                        correct <= correct + 8'(ans_valid && answer_obc == ref_ans);
                    end else timer <= timer + 1'b1;
                end
                GAP: begin
                    if (round < R_N) begin
                        st       <= ASK;
                        q_valid  <= 1'b1;
                        question <= WIDTH'(lfsr_step(lfsr));
                        timer    <= '0;
                    end else begin
                        st         <= EVAL;
                        check_pass <= !imperfect;
                        check_fail <= imperfect;
                    end
                end
                EVAL: begin
                    st        <= to_shut ? SHUTDOWN : IDLE;
                    override  <= to_shut;
                    obc_reset <= to_shut;
                    pulse_cnt <= '0;
                    if (imperfect && correct >= P_MIN) strikes <= strikes_inc;
                end
                SHUTDOWN: begin
                    if (clear) begin
                        st        <= IDLE;
                        override  <= 1'b0;
                        obc_reset <= 1'b0;
                    end else if (pulse_cnt == P_LAST) obc_reset <= 1'b0;
                    else pulse_cnt <= pulse_cnt + 1'b1;
                end
                default: st <= IDLE;
            endcase
            if (clear) strikes <= '0;
        end
    end
endmodule

// File: tb/tb_obc_challenge_monitor.sv
// tb_obc_challenge_monitor: directed checks of the challenge monitor with an
// independent LFSR/reference model driving a scripted OBC.
module tb_obc_challenge_monitor;
    logic       clk = 1'b0, reset = 1'b0, clear = 1'b0, ans_valid = 1'b0;
    logic [3:0] answer_obc = '0;
    logic [3:0] question, strikes;
    logic       q_valid, check_pass, check_fail, override, obc_reset;
    int         n_chk = 0, n_fail = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    logic [15:0] tmp;
    logic [3:0]  first_q;
    localparam logic [9:0] BAD2 = 10'b0000010010;

    obc_challenge_monitor dut (
        .clk(clk), .reset(reset), .clear(clear), .question(question), .q_valid(q_valid),
        .answer_obc(answer_obc), .ans_valid(ans_valid), .check_pass(check_pass),
        .check_fail(check_fail), .strikes(strikes), .override(override), .obc_reset(obc_reset)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ ({16{s[0]}} & 16'hB400);
    endfunction

    function automatic logic [3:0] m_ref(input logic [3:0] q);
        return {q[3] ^ q[2], q[2] ^ q[1], q[1] ^ q[0], ~q[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int exp, input bit poke);
        int n = 0;
        while (!q_valid && n < 200) begin
            ans_valid  = poke && (n % 3 == 0);
            answer_obc = 4'(n);
            n++;
            @(negedge clk);
        end
        ans_valid = 1'b0;
        chk("idle_len", n, exp);
    endtask

    // d = cycle of ASK in which the answer is given (1-based); d = 0 means silent
    task automatic do_round(input int d, input bit bad);
        int n = 0;
        while (!q_valid && n < 200) begin n++; @(negedge clk); end
        if (!q_valid) begin
            chk("q_valid_rise", q_valid, 1);
            return;
        end
        lfsr_m = m_step(lfsr_m);
        chk("question", question, lfsr_m[3:0]);
        n = 0;
        if (d == 0) begin
            while (q_valid && n < 40) begin n++; @(negedge clk); end
            chk("timeout_len", n, 16);
        end else begin
            repeat (d - 1) @(negedge clk);
            answer_obc = bad ? ~m_ref(lfsr_m[3:0]) : m_ref(lfsr_m[3:0]);
            ans_valid  = 1'b1;
            @(negedge clk);
            ans_valid = 1'b0;
            chk("gap_q_valid", q_valid, 0);
        end
    endtask

    task automatic run_check(input int d, input logic [9:0] bad, input bit pass);
        for (int r = 0; r < 10; r++) do_round(d, bad[r]);
        @(negedge clk);
        chk("check_pass", check_pass, pass);
        chk("check_fail", check_fail, !pass);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, qv, ovl;
        tmp = m_step(16'hACE1);
        first_q = tmp[3:0];
        repeat (3) @(negedge clk);
        chk("rst_question", question, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_strikes", strikes, 0);
        chk("rst_override", override, 0);
        chk("rst_obc_reset", obc_reset, 0);
        chk("rst_pass", check_pass, 0);
        chk("rst_fail", check_fail, 0);
        reset = 1'b1;
        wait_idle(64, 0);
        for (int k = 0; k < 5; k++) begin
            run_check(3, '0, 1);
            @(negedge clk);
            chk("good_strikes", strikes, 0);
            chk("good_override", override, 0);
        end
        for (int k = 1; k <= 3; k++) begin
            run_check(3, BAD2, 0);
            @(negedge clk);
            chk("bad_strikes", strikes, k);
            chk("bad_override", override, k == 3);
        end
        n = 0;
        while (obc_reset && n < 30) begin n++; @(negedge clk); end
        chk("obc_reset_len", n, 8);
        qv = 0;
        ovl = 0;
        for (int i = 0; i < 80; i++) begin
            qv += int'(q_valid);
            ovl += int'(!override);
            @(negedge clk);
        end
        chk("shutdown_no_q", qv, 0);
        chk("override_sticky", ovl, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_override", override, 0);
        chk("clear_strikes", strikes, 0);
        wait_idle(64, 0);
        run_check(0, '0, 0);
        @(negedge clk);
        chk("silent_override", override, 1);
        chk("silent_strikes", strikes, 0);
        chk("silent_obc_reset", obc_reset, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear2_override", override, 0);
        run_check(3, BAD2, 0);
        @(negedge clk);
        chk("pre_rst_strikes", strikes, 1);
        for (int r = 0; r < 4; r++) do_round(3, 0);
        for (int i = 0; i < 10 && !q_valid; i++) @(negedge clk);
        chk("round5_asking", q_valid, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_q_valid", q_valid, 0);
        chk("mid_rst_question", question, 0);
        chk("mid_rst_strikes", strikes, 0);
        chk("mid_rst_override", override, 0);
        chk("mid_rst_obc_reset", obc_reset, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_no_pulse", check_pass | check_fail, 0);
        reset = 1'b1;
        lfsr_m = 16'hACE1;
        wait_idle(64, 1);
        chk("reseed_first_q", question, first_q);
        run_check(16, '0, 1);
        @(negedge clk);
        chk("late_strikes", strikes, 0);
        chk("late_override", override, 0);
        run_check(3, BAD2, 0);
        @(negedge clk);
        run_check(3, BAD2, 0);
        @(negedge clk);
        chk("eval_pre_strikes", strikes, 2);
        run_check(3, BAD2, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("eval_clr_override", override, 0);
        chk("eval_clr_strikes", strikes, 0);
        chk("eval_clr_obc_reset", obc_reset, 0);
        wait_idle(64, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
